branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded at reset; nPC resets to RESET_PC+4.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: instr_valid  input  1  decoded instruction presented for sequencing.
REQ-005 SHALL have port: instr_ready  output  1  controller accepts instruction this cycle; accept = instr_valid & instr_ready.
REQ-006 SHALL have port: is_bicc  input  1  instruction is a Bicc conditional branch.
REQ-007 SHALL have port: is_call  input  1  instruction is CALL; is_bicc and is_call never both 1.
REQ-008 SHALL have port: cond  input  4  Bicc condition field.
REQ-009 SHALL have port: annul  input  1  Bicc annul bit (a).
REQ-010 SHALL have port: disp  input  30  disp30 for CALL; disp[21:0] is disp22 for Bicc.
REQ-011 SHALL have port: icc  input  4  condition codes {N,Z,V,C}, sampled at accept.
REQ-012 SHALL have port: pc  output  32  PC of the instruction being accepted.
REQ-013 SHALL have port: npc  output  32  next PC.
REQ-014 SHALL have port: squash  output  1  current presented instruction is annulled; it is accepted but has no architectural effect.
REQ-015 SHALL have port: taken  output  1  one-cycle pulse: last evaluated branch/call was taken.

Function
REQ-016 SHALL implement an FSM with states RUN and EVAL.
REQ-017 RUN: instr_ready=1; non-CTI accept -> pc<=npc, npc<=npc+4, stay in RUN.
REQ-018 RUN: CTI accept (is_bicc or is_call) -> latch pc, cond, annul, disp, icc; go to EVAL; pc/npc unchanged this cycle.
REQ-019 EVAL: instr_ready=0 for exactly one cycle; compute target and taken; pc<=npc; npc<=taken?target:npc+4; return to RUN. CTI-to-next-accept latency is 2 cycles.
REQ-020 Bicc target SHALL be latched_pc + (sign_extend(disp22) << 2); CALL target SHALL be latched_pc + (disp30 << 2); all sums mod 2^32, wrap without flag.
REQ-021 CALL SHALL always be taken and never annuls its delay slot.
REQ-022 Bicc taken SHALL follow the SPARC table: 0 BN never; 8 BA always; 1 BE Z; 9 BNE !Z; 2 BLE Z|(N^V); A BG !(Z|(N^V)); 3 BL N^V; B BGE !(N^V); 4 BLEU C|Z; C BGU !(C|Z); 5 BCS C; D BCC !C; 6 BNEG N; E BPOS !N; 7 BVS V; F BVC !V.
REQ-023 Annul: delay slot annulled if annul=1 and (branch untaken, or cond=8 BA); annulled when annul=1 and cond=0 BN.
REQ-024 squash SHALL assert during the RUN cycle(s) until the delay-slot instruction is accepted, then clear at that accept; squashed instruction still advances pc/npc.
REQ-025 taken SHALL pulse high in the EVAL-exit cycle only; 0 otherwise.
REQ-026 A CTI in a delay slot (DCTI couple) SHALL be evaluated normally; if squashed, it SHALL be treated as non-CTI (no EVAL).
REQ-027 instr_valid=0 in RUN SHALL hold all state; pc/npc/squash stable.

Reset
REQ-028 reset SHALL dominate all inputs, including mid-EVAL: pc=RESET_PC, npc=RESET_PC+4, state=RUN, squash=0, taken=0, latched fields cleared; instr_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-029 Macro BRANCH_CTRL_ANNUL_EN: defined -> REQ-023/024 annul behaviour implemented; undefined -> annul input ignored, squash tied 0, no annul state flop.

Verification
REQ-030 Reset, 3 non-CTI accepts -> pc 0,4,8; npc 4,8,12; then pc=12.
REQ-031 pc=0x100, BE disp22=0x3, Z=1 -> instr_ready low 1 cycle, taken pulse, next accept pc=0x104, npc=0x10C.
REQ-032 pc=0x200, BNE disp22=0x3FFFFE (-2), Z=1, annul=1 -> untaken, squash=1 on delay slot at 0x204, then pc=0x208, squash=0.
REQ-033 pc=0x300, BA annul=1 disp22=0x10 -> delay slot 0x304 squashed, next pc=0x340.
REQ-034 pc=0xFFFF_FFF0, CALL disp30=0x8 -> target 0x0000_0010 (wrap), squash=0.
REQ-035 reset asserted during EVAL of a taken branch -> pc=RESET_PC, npc=RESET_PC+4, taken=0, squash=0.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: instruction-sequencing bus between the decode stage and
// the branch controller. The decoder side is the master, the controller
// is the slave.
interface branch_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic        is_bicc;
  logic        is_call;
  logic [3:0]  cond;
  logic        annul;
  logic [29:0] disp;
  logic [3:0]  icc;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        squash;
  logic        taken;

  modport master (
    output instr_valid, is_bicc, is_call, cond, annul, disp, icc,
    input  instr_ready, pc, npc, squash, taken
  );

  modport slave (
    input  instr_valid, is_bicc, is_call, cond, annul, disp, icc,
    output instr_ready, pc, npc, squash, taken
  );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: SPARC-style PC/nPC sequencer for Bicc and CALL.
// A control-transfer instruction costs one extra EVAL cycle in which the
// condition is resolved and nPC is redirected.
// Optional macro BRANCH_CTRL_ANNUL_EN enables delay-slot annulment
// (squash output); without it the annul input is ignored and squash is 0.
//
// state | meaning
// RUN   | accepting instructions, advancing pc/npc
// EVAL  | resolving the latched CTI, instr_ready low for one cycle
module branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk,
  input logic    reset,
  branch_ctrl_if.slave bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_EVAL = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [3:0]  cond_q, cond_d;
  logic [3:0]  icc_q, icc_d;
  logic [29:0] disp_q, disp_d;
  logic        is_call_q, is_call_d;
  logic        taken_q, taken_d;
  logic        squash_w;

  logic        accept;
  logic        is_cti;
  logic        take;
  logic [31:0] target;

`ifdef BRANCH_CTRL_ANNUL_EN
  logic annul_q, annul_d;
  logic squash_q, squash_d;
  assign squash_w = squash_q;
`else
  logic unused_annul;
  assign unused_annul = bus.annul;
  assign squash_w     = 1'b0;
`endif

  // SPARC integer condition evaluation; cond[3] inverts the base test
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cc, r;
    {n, z, v, cc} = f;
    case (c[2:0])
      3'd0:    r = 1'b0;
      3'd1:    r = z;
      3'd2:    r = z | (n ^ v);
      3'd3:    r = n ^ v;
      3'd4:    r = cc | z;
      3'd5:    r = cc;
      3'd6:    r = n;
      default: r = v;
    endcase
    return c[3] ? ~r : r;
  endfunction

  assign accept = bus.instr_valid & (state_q == ST_RUN);
  assign is_cti = bus.is_bicc | bus.is_call;

  // Branch resolution from the latched CTI; pc_q still holds the CTI's PC
  always_comb begin
    take   = is_call_q | cond_true(cond_q, icc_q);
    target = is_call_q ? (pc_q + {disp_q, 2'b00})
                       : (pc_q + {{8{disp_q[21]}}, disp_q[21:0], 2'b00});
  end

  // Next-state, sequencing and latch logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    cond_d    = cond_q;
    icc_d     = icc_q;
    disp_d    = disp_q;
    is_call_d = is_call_q;
    taken_d   = 1'b0;
`ifdef BRANCH_CTRL_ANNUL_EN
    annul_d   = annul_q;
    squash_d  = squash_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          // An annulled CTI in a delay slot is sequenced like any other instruction
          if (is_cti && !squash_w) begin
            state_d   = ST_EVAL;
            cond_d    = bus.cond;
            icc_d     = bus.icc;
            disp_d    = bus.disp;
            is_call_d = bus.is_call;
`ifdef BRANCH_CTRL_ANNUL_EN
            annul_d   = bus.annul & bus.is_bicc;
`endif
          end else begin
            pc_d  = npc_q;
            npc_d = npc_q + 32'd4;
          end
`ifdef BRANCH_CTRL_ANNUL_EN
          squash_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_RUN;
        pc_d    = npc_q;
        npc_d   = take ? target : (npc_q + 32'd4);
        taken_d = take;
`ifdef BRANCH_CTRL_ANNUL_EN
        // BA,a annuls its delay slot even though it is taken
        squash_d = annul_q & (~take | (cond_q == 4'h8));
`endif
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      npc_q     <= RESET_PC + 32'd4;
      cond_q    <= 4'h0;
      icc_q     <= 4'h0;
      disp_q    <= 30'h0;
      is_call_q <= 1'b0;
      taken_q   <= 1'b0;
`ifdef BRANCH_CTRL_ANNUL_EN
      annul_q   <= 1'b0;
      squash_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      cond_q    <= cond_d;
      icc_q     <= icc_d;
      disp_q    <= disp_d;
      is_call_q <= is_call_d;
      taken_q   <= taken_d;
`ifdef BRANCH_CTRL_ANNUL_EN
      annul_q   <= annul_d;
      squash_q  <= squash_d;
`endif
    end
  end

  assign bus.instr_ready = (state_q == ST_RUN);
  assign bus.pc          = pc_q;
  assign bus.npc         = npc_q;
  assign bus.squash      = squash_w;
  assign bus.taken       = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed vectors with hand-computed expectations.
module tb_branch_ctrl;

`ifdef BRANCH_CTRL_ANNUL_EN
  localparam bit ANNUL_EN = 1'b1;
`else
  localparam bit ANNUL_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  branch_ctrl_if bif ();

  branch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
  endtask

  // Present one cycle of inputs, then settle just after the edge
  task automatic step(input logic v, input logic bicc, input logic call,
                      input logic [3:0] c, input logic a,
                      input logic [29:0] d, input logic [3:0] f);
    bif.instr_valid = v;
    bif.is_bicc     = bicc;
    bif.is_call     = call;
    bif.cond        = c;
    bif.annul       = a;
    bif.disp        = d;
    bif.icc         = f;
    @(posedge clk);
    #1;
  endtask

  task automatic plain();
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 30'h0, 4'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 30'h0, 4'h0);
  endtask

  // CALL from 'from' (npc = from+4) to 'to', then retire the delay slot
  task automatic goto_pc(input logic [31:0] from, input logic [31:0] to);
    logic [31:0] delta;
    delta = (to - from) >> 2;
    step(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, delta[29:0], 4'h0);
    idle();
    plain();
    chk("goto_pc", bif.pc, to);
  endtask

  typedef struct {
    logic [3:0] cond;
    logic [3:0] icc;
    logic       annul;
    logic       tk;
    logic       sq;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] p;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    bif.instr_valid = 1'b0;
    bif.is_bicc = 1'b0;
    bif.is_call = 1'b0;
    bif.cond    = 4'h0;
    bif.annul   = 1'b0;
    bif.disp    = 30'h0;
    bif.icc     = 4'h0;

    //        cond   icc      a     taken squash
    vecs[0] = '{4'h2, 4'b1000, 1'b0, 1'b1, 1'b0};  // BLE  N^V
    vecs[1] = '{4'hA, 4'b1000, 1'b0, 1'b0, 1'b0};  // BG
    vecs[2] = '{4'h4, 4'b0001, 1'b0, 1'b1, 1'b0};  // BLEU C
    vecs[3] = '{4'hC, 4'b0000, 1'b0, 1'b1, 1'b0};  // BGU
    vecs[4] = '{4'h0, 4'b1111, 1'b1, 1'b0, 1'b1};  // BN,a
    vecs[5] = '{4'hB, 4'b1010, 1'b0, 1'b1, 1'b0};  // BGE N==V
    vecs[6] = '{4'h7, 4'b0000, 1'b1, 1'b0, 1'b1};  // BVS,a untaken
    vecs[7] = '{4'hD, 4'b0000, 1'b1, 1'b1, 1'b0};  // BCC,a taken

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk("rst_pc", bif.pc, 32'h0);
    chk("rst_npc", bif.npc, 32'h4);
    chk("rst_ready", bif.instr_ready, 1'b1);
    chk("rst_squash", bif.squash, 1'b0);
    chk("rst_taken", bif.taken, 1'b0);

    // straight-line sequencing
    plain();
    chk("seq_pc4", bif.pc, 32'h4);
    chk("seq_npc8", bif.npc, 32'h8);
    plain();
    chk("seq_pc8", bif.pc, 32'h8);
    chk("seq_npc12", bif.npc, 32'hC);
    plain();
    chk("seq_pc12", bif.pc, 32'hC);
    idle();
    chk("hold_pc", bif.pc, 32'hC);
    chk("hold_npc", bif.npc, 32'h10);

    // BE taken
    goto_pc(32'hC, 32'h100);
    step(1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 30'h3, 4'b0100);
    chk("be_ready_low", bif.instr_ready, 1'b0);
    chk("be_pc_hold", bif.pc, 32'h100);
    idle();
    chk("be_ready", bif.instr_ready, 1'b1);
    chk("be_taken", bif.taken, 1'b1);
    chk("be_pc", bif.pc, 32'h104);
    chk("be_npc", bif.npc, 32'h10C);
    plain();
    chk("be_taken_clr", bif.taken, 1'b0);
    chk("be_tgt_pc", bif.pc, 32'h10C);

    // BNE,a untaken with negative displacement
    goto_pc(32'h10C, 32'h200);
    step(1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 30'h3FFFFE, 4'b0100);
    idle();
    chk("bne_taken", bif.taken, 1'b0);
    chk("bne_pc", bif.pc, 32'h204);
    chk("bne_npc", bif.npc, 32'h208);
    chk("bne_squash", bif.squash, ANNUL_EN ? 1'b1 : 1'b0);
    idle();
    chk("bne_squash_hold", bif.squash, ANNUL_EN ? 1'b1 : 1'b0);
    plain();
    chk("bne_after_pc", bif.pc, 32'h208);
    chk("bne_after_sq", bif.squash, 1'b0);

    // BA,a
    goto_pc(32'h208, 32'h300);
    step(1'b1, 1'b1, 1'b0, 4'h8, 1'b1, 30'h10, 4'b0000);
    idle();
    chk("ba_taken", bif.taken, 1'b1);
    chk("ba_pc", bif.pc, 32'h304);
    chk("ba_squash", bif.squash, ANNUL_EN ? 1'b1 : 1'b0);
    plain();
    chk("ba_tgt_pc", bif.pc, 32'h340);
    chk("ba_tgt_npc", bif.npc, 32'h344);
    chk("ba_sq_clr", bif.squash, 1'b0);

    // condition table, disp22 = 4 so target = P + 16
    p = 32'h340;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, vecs[i].cond, vecs[i].annul, 30'h4, vecs[i].icc);
      idle();
      chk($sformatf("tbl%0d_taken", i), bif.taken, vecs[i].tk);
      chk($sformatf("tbl%0d_squash", i), bif.squash, ANNUL_EN ? vecs[i].sq : 1'b0);
      plain();
      p = vecs[i].tk ? (p + 32'd16) : (p + 32'd8);
      chk($sformatf("tbl%0d_pc", i), bif.pc, p);
    end

    // CALL with address wrap
    goto_pc(p, 32'hFFFF_FFF0);
    step(1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 30'h8, 4'b0000);
    idle();
    chk("call_taken", bif.taken, 1'b1);
    chk("call_pc", bif.pc, 32'hFFFF_FFF4);
    chk("call_npc", bif.npc, 32'h0000_0010);
    chk("call_squash", bif.squash, 1'b0);
    plain();
    chk("call_tgt_pc", bif.pc, 32'h0000_0010);

    // reset during EVAL of a taken BA
    step(1'b1, 1'b1, 1'b0, 4'h8, 1'b0, 30'h4, 4'b0000);
    chk("mid_eval_ready", bif.instr_ready, 1'b0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("reval_pc", bif.pc, 32'h0);
    chk("reval_npc", bif.npc, 32'h4);
    chk("reval_taken", bif.taken, 1'b0);
    chk("reval_squash", bif.squash, 1'b0);
    chk("reval_ready", bif.instr_ready, 1'b1);
    plain();
    chk("reval_pc4", bif.pc, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
